// File: rtl/l2_req_queue.sv
// rtl/l2_req_queue.sv - show-ahead request FIFO between the instruction cache and the next-level cache
// Optional READ coalescing into the tail entry is enabled by defining L2_REQ_QUEUE_MERGE_EN.
module l2_req_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 26,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   input  logic [1:0]               req_cmd,
   input  logic [ADDR_W-1:0]        req_addr,
   output logic                     req_ready,
   output logic                     mem_valid,
   output logic [1:0]               mem_cmd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         reads_fwd,
   output logic [CNT_W-1:0]         writes_fwd,
   output logic [CNT_W-1:0]         drops,
   output logic [CNT_W-1:0]         merges
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   logic [1:0]        cmd_mem  [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_nxt;

   logic acc;
   logic cmd_ok;
   logic merge_hit;
   logic store;
   logic drop;
   logic deq;

   assign acc    = req_valid && req_ready;
   assign cmd_ok = (req_cmd == CMD_READ) || (req_cmd == CMD_WRITE);
   assign deq    = mem_valid && mem_ready;

`ifdef L2_REQ_QUEUE_MERGE_EN
   logic [PTR_W-1:0] tail_ptr;
   assign tail_ptr = wr_ptr - PTR_W'(1);
   // A READ hitting the tail READ is absorbed unless that tail is leaving this very cycle.
   assign merge_hit = acc && (req_cmd == CMD_READ) && (level != '0)
                      && (cmd_mem[tail_ptr] == CMD_READ)
                      && (addr_mem[tail_ptr] == req_addr)
                      && !(deq && (level == LVL_W'(1)));
`else
   assign merge_hit = 1'b0;
`endif

   assign store = acc && cmd_ok && !merge_hit;
   assign drop  = acc && !cmd_ok;

   // Show-ahead head; outputs read as zero while the queue is empty.
   assign mem_valid = (level != '0);
   assign mem_cmd   = mem_valid ? cmd_mem[rd_ptr]  : 2'b00;
   assign mem_addr  = mem_valid ? addr_mem[rd_ptr] : '0;

   // Next occupancy from enqueue/dequeue of this cycle.
   always_comb begin
      level_nxt = level;
      case ({store, deq})
         2'b10:   level_nxt = level + LVL_W'(1);
         2'b01:   level_nxt = level - LVL_W'(1);
         default: level_nxt = level;
      endcase
   end

   // Entry storage; contents are only observed once qualified by level.
   always_ff @(posedge clk) begin
      if (store) begin
         cmd_mem[wr_ptr]  <= req_cmd;
         addr_mem[wr_ptr] <= req_addr;
      end
   end

   // Pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         req_ready <= 1'b1;
      end else begin
         if (store) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq)   rd_ptr <= rd_ptr + PTR_W'(1);
         level     <= level_nxt;
         req_ready <= (level_nxt != LVL_W'(DEPTH));
      end
   end

   // Statistics counters, wrapping silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reads_fwd  <= '0;
         writes_fwd <= '0;
         drops      <= '0;
      end else begin
         if (deq && (mem_cmd == CMD_READ))  reads_fwd  <= reads_fwd + CNT_W'(1);
         if (deq && (mem_cmd == CMD_WRITE)) writes_fwd <= writes_fwd + CNT_W'(1);
         if (drop)                          drops      <= drops + CNT_W'(1);
      end
   end

`ifdef L2_REQ_QUEUE_MERGE_EN
   // Coalesced READ counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) merges <= '0;
      else if (merge_hit) merges <= merges + CNT_W'(1);
   end
`else
   assign merges = '0;
`endif

endmodule
